// File: rtl/core_pkg.sv
// Shared core constants for the rename / issue / execute slice.
// Holds micro-op field widths used by the schedulers and the rule that
// physical tag 0 is permanently ready.
package core_pkg;

    localparam int PREG_W    = 6;   // physical register tag width
    localparam int OPCODE_W  = 7;
    localparam int ALU_SIG_W = 3;
    localparam int IMM_W     = 32;

    // Physical tag 0 is hard-wired to a constant register and never waits.
    localparam logic TAG0_READY = 1'b1;

endpackage

// File: rtl/age_matrix_select.sv
// Oldest-first selector driven by an age matrix.
// Row i of age lists the entries older than entry i (age[i][j]=1 means j is
// older than i). An entry is granted when it is a candidate and no older
// entry is also a candidate. Purely combinational.
//   cand      in   one bit per entry, entry is eligible
//   age       in   NUM_ENTRIES x NUM_ENTRIES age matrix
//   grant     out  one-hot oldest candidate
//   any_grant out  at least one candidate exists
module age_matrix_select #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic [NUM_ENTRIES-1:0]                  cand,
    input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age,
    output logic [NUM_ENTRIES-1:0]                  grant,
    output logic                                    any_grant
);

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_row
        assign grant[i] = cand[i] & ~|(age[i] & cand);
    end

    assign any_grant = |cand;

endmodule

// File: rtl/issue_scheduler.sv
// Reservation-station scheduler between rename and the issue stage.
// Buffers renamed micro-ops until both source tags are ready (learned from
// write-back broadcasts), then hands the oldest ready op to a registered
// valid/ready issue port.
//   clk, rst          clock, synchronous active-low reset
//   flush             squash every entry and the issue register
//   disp_*            dispatch port from rename (valid/ready + micro-op)
//   wb_valid, wb_tag  write-back tag broadcasts, port k at [k*PREG_W +: PREG_W]
//   issue_*           issued micro-op (valid/ready)
//   count             occupied entries, not counting the issue register
module issue_scheduler #(
    parameter int NUM_ENTRIES = 8,
    parameter int WB_PORTS    = 2,
    parameter int PREG_W      = core_pkg::PREG_W,
    parameter int CNT_W       = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              disp_valid,
    output logic                              disp_ready,
    input  logic [core_pkg::OPCODE_W-1:0]     disp_opcode,
    input  logic [core_pkg::ALU_SIG_W-1:0]    disp_alu_sig,
    input  logic [core_pkg::IMM_W-1:0]        disp_imm,
    input  logic [PREG_W-1:0]                 disp_rrd,
    input  logic [PREG_W-1:0]                 disp_rrs1,
    input  logic [PREG_W-1:0]                 disp_rrs2,
    input  logic                              disp_rs1_rdy,
    input  logic                              disp_rs2_rdy,
    input  logic [WB_PORTS-1:0]               wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]        wb_tag,
    output logic                              issue_valid,
    input  logic                              issue_ready,
    output logic [core_pkg::OPCODE_W-1:0]     issue_opcode,
    output logic [core_pkg::ALU_SIG_W-1:0]    issue_alu_sig,
    output logic [core_pkg::IMM_W-1:0]        issue_imm,
    output logic [PREG_W-1:0]                 issue_rrd,
    output logic [PREG_W-1:0]                 issue_rrs1,
    output logic [PREG_W-1:0]                 issue_rrs2,
    output logic [CNT_W-1:0]                  count
);
    import core_pkg::*;

    logic [NUM_ENTRIES-1:0]                  ent_valid, ent_rdy1, ent_rdy2;
    logic [NUM_ENTRIES-1:0][OPCODE_W-1:0]    ent_opcode;
    logic [NUM_ENTRIES-1:0][ALU_SIG_W-1:0]   ent_alu_sig;
    logic [NUM_ENTRIES-1:0][IMM_W-1:0]       ent_imm;
    logic [NUM_ENTRIES-1:0][PREG_W-1:0]      ent_rrd, ent_rrs1, ent_rrs2;
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age;

    logic [NUM_ENTRIES-1:0] cand, grant, alloc;
    logic                   any_grant, load, sel_fire, disp_fire, found;
    logic                   disp_rdy1, disp_rdy2;

    logic [OPCODE_W-1:0]    win_opcode;
    logic [ALU_SIG_W-1:0]   win_alu_sig;
    logic [IMM_W-1:0]       win_imm;
    logic [PREG_W-1:0]      win_rrd, win_rrs1, win_rrs2;

    // A tag is ready if it is the hard-wired tag 0 or is broadcast this cycle.
    function automatic logic woken(input logic [PREG_W-1:0]          tag,
                                   input logic [WB_PORTS-1:0]        wv,
                                   input logic [WB_PORTS*PREG_W-1:0] wt);
        logic hit;
        hit = TAG0_READY && (tag == '0);
        for (int k = 0; k < WB_PORTS; k++)
            if (wv[k] && wt[k*PREG_W +: PREG_W] == tag) hit = 1'b1;
        return hit;
    endfunction

    assign cand       = ent_valid & ent_rdy1 & ent_rdy2;
    assign load       = !issue_valid || issue_ready;
    assign sel_fire   = load && any_grant;
    // Registered count only: a slot freed this cycle is reused next cycle.
    assign disp_ready = (count < CNT_W'(NUM_ENTRIES));
    assign disp_fire  = disp_valid && disp_ready;
    // Bypass: a broadcast in the dispatch cycle is folded into the new entry.
    assign disp_rdy1  = disp_rs1_rdy || woken(disp_rrs1, wb_valid, wb_tag);
    assign disp_rdy2  = disp_rs2_rdy || woken(disp_rrs2, wb_valid, wb_tag);

    age_matrix_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_select (
        .cand      (cand),
        .age       (age),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // Lowest-index free slot.
    always_comb begin
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (!ent_valid[i] && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
    end

    // One-hot grant -> OR-mux of the winner's fields.
    always_comb begin
        win_opcode  = '0;
        win_alu_sig = '0;
        win_imm     = '0;
        win_rrd     = '0;
        win_rrs1    = '0;
        win_rrs2    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (grant[i]) begin
                win_opcode  = win_opcode  | ent_opcode[i];
                win_alu_sig = win_alu_sig | ent_alu_sig[i];
                win_imm     = win_imm     | ent_imm[i];
                win_rrd     = win_rrd     | ent_rrd[i];
                win_rrs1    = win_rrs1    | ent_rrs1[i];
                win_rrs2    = win_rrs2    | ent_rrs2[i];
            end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid     <= '0;
            ent_rdy1      <= '0;
            ent_rdy2      <= '0;
            age           <= '0;
            count         <= '0;
            issue_valid   <= 1'b0;
            issue_opcode  <= '0;
            issue_alu_sig <= '0;
            issue_imm     <= '0;
            issue_rrd     <= '0;
            issue_rrs1    <= '0;
            issue_rrs2    <= '0;
        end else if (flush) begin
            ent_valid   <= '0;
            count       <= '0;
            issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_rdy1[i] <= ent_rdy1[i] | woken(ent_rrs1[i], wb_valid, wb_tag);
                ent_rdy2[i] <= ent_rdy2[i] | woken(ent_rrs2[i], wb_valid, wb_tag);
                if (sel_fire && grant[i]) ent_valid[i] <= 1'b0;
                if (disp_fire && alloc[i]) begin
                    ent_valid[i]   <= 1'b1;
                    ent_rdy1[i]    <= disp_rdy1;
                    ent_rdy2[i]    <= disp_rdy2;
                    ent_opcode[i]  <= disp_opcode;
                    ent_alu_sig[i] <= disp_alu_sig;
                    ent_imm[i]     <= disp_imm;
                    ent_rrd[i]     <= disp_rrd;
                    ent_rrs1[i]    <= disp_rrs1;
                    ent_rrs2[i]    <= disp_rrs2;
                    // Everything still resident is older than the newcomer.
                    age[i]         <= ent_valid & ~(sel_fire ? grant : '0);
                end
            end
            // The newcomer is older than nobody: clear its column so stale
            // bits from a previous occupant of this slot cannot linger.
            for (int r = 0; r < NUM_ENTRIES; r++)
                for (int i = 0; i < NUM_ENTRIES; i++)
                    if (disp_fire && alloc[i] && r != i) age[r][i] <= 1'b0;

            if (load) begin
                issue_valid <= any_grant;
                if (any_grant) begin
                    issue_opcode  <= win_opcode;
                    issue_alu_sig <= win_alu_sig;
                    issue_imm     <= win_imm;
                    issue_rrd     <= win_rrd;
                    issue_rrs1    <= win_rrs1;
                    issue_rrs2    <= win_rrs2;
                end
            end

            count <= count + CNT_W'(disp_fire) - CNT_W'(sel_fire);
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: each task drives a scenario cycle by
// cycle and checks outputs #1 after the rising edge against hand-derived values.
module tb_issue_scheduler;

    logic        tb_clk = 1'b0;
    logic        rst, flush, disp_valid, disp_ready;
    logic [6:0]  disp_opcode;
    logic [2:0]  disp_alu_sig;
    logic [31:0] disp_imm;
    logic [5:0]  disp_rrd, disp_rrs1, disp_rrs2;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [1:0]  wb_valid;
    logic [11:0] wb_tag;
    logic        issue_valid, issue_ready;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_alu_sig;
    logic [31:0] issue_imm;
    logic [5:0]  issue_rrd, issue_rrs1, issue_rrs2;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    issue_scheduler dut (
        .clk(tb_clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_alu_sig(disp_alu_sig), .disp_imm(disp_imm),
        .disp_rrd(disp_rrd), .disp_rrs1(disp_rrs1), .disp_rrs2(disp_rrs2),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_alu_sig(issue_alu_sig), .issue_imm(issue_imm),
        .issue_rrd(issue_rrd), .issue_rrs1(issue_rrs1), .issue_rrs2(issue_rrs2),
        .count(count)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    // Drive a dispatch; opcode/imm derived from rrd so fields are traceable.
    task automatic disp(input logic v, input logic [5:0] rd, input logic [5:0] s1,
                        input logic [5:0] s2, input logic r1, input logic r2);
        disp_valid   = v;
        disp_rrd     = rd;
        disp_rrs1    = s1;
        disp_rrs2    = s2;
        disp_rs1_rdy = r1;
        disp_rs2_rdy = r2;
        disp_opcode  = {1'b0, rd};
        disp_alu_sig = rd[2:0];
        disp_imm     = 32'h1000 + {26'd0, rd};
    endtask

    task automatic idle();
        disp(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
        wb_valid = 2'b00;
        wb_tag   = 12'd0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        issue_ready = 1'b1;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b exp 0", issue_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if ({issue_opcode, issue_alu_sig, issue_imm, issue_rrd, issue_rrs1, issue_rrs2} !== 64'd0) begin
            errors++; $display("FAIL reset_fields: rrd=%0d imm=%h exp all zero", issue_rrd, issue_imm); end
        step();
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b exp 1", disp_ready); end
    endtask

    task automatic test_single();
        disp(1'b1, 6'd5, 6'd0, 6'd0, 1'b0, 1'b0);   // tag 0 counts as ready
        step(); idle();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL single_c1: valid=%b count=%0d exp 0/1", issue_valid, count); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd5) begin errors++; $display("FAIL single_issue: valid=%b rrd=%0d exp 1/5", issue_valid, issue_rrd); end
        checks++; if (issue_imm !== 32'h1005 || issue_opcode !== 7'd5 || issue_alu_sig !== 3'd5) begin
            errors++; $display("FAIL single_fields: imm=%h op=%0d alu=%0d exp 1005/5/5", issue_imm, issue_opcode, issue_alu_sig); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count: got %0d exp 0", count); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b exp 0", issue_valid); end
    endtask

    task automatic test_wakeup_order();
        disp(1'b1, 6'd10, 6'd7, 6'd0, 1'b0, 1'b1);  // A waits on tag 7
        step();
        disp(1'b1, 6'd11, 6'd3, 6'd4, 1'b1, 1'b1);  // B ready
        step(); idle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_none: got %b exp 0", issue_valid); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd11) begin errors++; $display("FAIL order_b_first: valid=%b rrd=%0d exp 1/11", issue_valid, issue_rrd); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL order_count: got %0d exp 1", count); end
        wb_valid = 2'b01; wb_tag = {6'd0, 6'd7};
        step(); idle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_gap: got %b exp 0", issue_valid); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd10 || issue_rrs1 !== 6'd7) begin
            errors++; $display("FAIL order_a_woken: valid=%b rrd=%0d rrs1=%0d exp 1/10/7", issue_valid, issue_rrd, issue_rrs1); end
        step();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL order_drain: valid=%b count=%0d exp 0/0", issue_valid, count); end
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b0;
        disp(1'b1, 6'd21, 6'd0, 6'd0, 1'b1, 1'b1); step();
        disp(1'b1, 6'd22, 6'd0, 6'd0, 1'b1, 1'b1); step();
        // Z lands in slot 0 (freed by X) but must still rank younger than Y.
        disp(1'b1, 6'd23, 6'd0, 6'd0, 1'b1, 1'b1);
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd21) begin errors++; $display("FAIL b2b_first: valid=%b rrd=%0d exp 1/21", issue_valid, issue_rrd); end
        step(); idle();
        checks++; if (issue_rrd !== 6'd21 || count !== 4'd2) begin errors++; $display("FAIL b2b_hold: rrd=%0d count=%0d exp 21/2", issue_rrd, count); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd21) begin errors++; $display("FAIL b2b_stable: valid=%b rrd=%0d exp 1/21", issue_valid, issue_rrd); end
        issue_ready = 1'b1;
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd22) begin errors++; $display("FAIL b2b_second: valid=%b rrd=%0d exp 1/22", issue_valid, issue_rrd); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd23) begin errors++; $display("FAIL b2b_third: valid=%b rrd=%0d exp 1/23", issue_valid, issue_rrd); end
        step();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL b2b_drain: valid=%b count=%0d exp 0/0", issue_valid, count); end
    endtask

    task automatic test_bypass();
        disp(1'b1, 6'd30, 6'd0, 6'd9, 1'b1, 1'b0);
        wb_valid = 2'b10; wb_tag = {6'd9, 6'd0};
        step(); idle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_c1: got %b exp 0", issue_valid); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd30 || issue_rrs2 !== 6'd9) begin
            errors++; $display("FAIL bypass_issue: valid=%b rrd=%0d rrs2=%0d exp 1/30/9", issue_valid, issue_rrd, issue_rrs2); end
        step();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b exp 1", i, disp_ready); end
            disp(1'b1, 6'(i + 1), 6'(40 + i), 6'd0, 1'b0, 1'b1);
            step();
        end
        disp(1'b1, 6'd33, 6'd0, 6'd0, 1'b1, 1'b1);  // 9th attempt while full
        checks++; if (disp_ready !== 1'b0 || count !== 4'd8) begin errors++; $display("FAIL full_block: ready=%b count=%0d exp 0/8", disp_ready, count); end
        step(); idle();
        checks++; if (count !== 4'd8 || issue_valid !== 1'b0) begin errors++; $display("FAIL full_ignored: count=%0d valid=%b exp 8/0", count, issue_valid); end
        wb_valid = 2'b01; wb_tag = {6'd0, 6'd43};
        step(); idle();
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_still: got %b exp 0", disp_ready); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rrd !== 6'd4 || count !== 4'd7 || disp_ready !== 1'b1) begin
            errors++; $display("FAIL full_release: valid=%b rrd=%0d count=%0d ready=%b exp 1/4/7/1", issue_valid, issue_rrd, count, disp_ready); end
        flush = 1'b1;
        step(); idle();
        checks++; if (count !== 4'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL full_flush: count=%0d valid=%b exp 0/0", count, issue_valid); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        disp(1'b1, 6'd50, 6'd0, 6'd0, 1'b1, 1'b1); step();
        for (int i = 0; i < 4; i++) begin
            disp(1'b1, 6'(51 + i), 6'd60, 6'd0, 1'b0, 1'b1); step();
        end
        idle();
        checks++; if (count !== 4'd4 || issue_valid !== 1'b1 || issue_rrd !== 6'd50) begin
            errors++; $display("FAIL flush_pre: count=%0d valid=%b rrd=%0d exp 4/1/50", count, issue_valid, issue_rrd); end
        flush = 1'b1;
        disp(1'b1, 6'd55, 6'd0, 6'd0, 1'b1, 1'b1);
        wb_valid = 2'b01; wb_tag = {6'd0, 6'd60};
        step(); idle();
        issue_ready = 1'b1;
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL flush_clear: valid=%b count=%0d exp 0/0", issue_valid, count); end
        step(); step();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL flush_discard: valid=%b count=%0d exp 0/0", issue_valid, count); end
    endtask

    task automatic test_reset_mid();
        issue_ready = 1'b0;
        disp(1'b1, 6'd12, 6'd0, 6'd0, 1'b1, 1'b1); step();
        disp(1'b1, 6'd13, 6'd0, 6'd0, 1'b1, 1'b1); step(); idle();
        rst = 1'b0; flush = 1'b1;
        disp(1'b1, 6'd14, 6'd0, 6'd0, 1'b1, 1'b1);
        step(); idle(); rst = 1'b1;
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0 || issue_rrd !== 6'd0) begin
            errors++; $display("FAIL mid_reset: valid=%b count=%0d rrd=%0d exp 0/0/0", issue_valid, count, issue_rrd); end
        issue_ready = 1'b1;
        step(); step();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_empty: got %b exp 0", issue_valid); end
    endtask

    initial begin
        rst = 1'b0;
        issue_ready = 1'b1;
        idle();
        test_reset();
        test_single();
        test_wakeup_order();
        test_back_to_back();
        test_bypass();
        test_full();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
